// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
package rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    HOLD
  } state_e;

  localparam int LOCK_CNT_W = 8;

  // One spare bit over the maximum count, so terminal compares never see a wrap.
  function automatic int cnt_w(input int max_cnt);
    return $clog2(max_cnt) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Status/reset bundle between the sequencer and the logic it gates.
interface rst_seq_ctrl_if
  import rst_seq_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3
) ();
  logic                  pll_locked;
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] rst_n_out;
  logic                  sys_ready;
  logic [LOCK_CNT_W-1:0] lock_loss_cnt;
  logic                  status_led;

  modport master (
    output pll_locked, soft_rst_req,
    input  rst_n_out, sys_ready, lock_loss_cnt, status_led
  );

  modport slave (
    input  pll_locked, soft_rst_req,
    output rst_n_out, sys_ready, lock_loss_cnt, status_led
  );
endinterface

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single-bit asynchronous status signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/rst_seq_ctrl.sv
// Qualifies PLL lock, then releases staged active-low resets in order;
// re-asserts everything on lock loss or a soft-reset request.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP_CYC   = 256,
  parameter int NUM_STAGES      = 3,
  parameter int LED_HALF_CYC    = 25_000_000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  rst_seq_ctrl_if.slave  bus
);
  localparam int STAB_W = cnt_w(LOCK_STABLE_CYC);
  localparam int GAP_W  = cnt_w(STAGE_GAP_CYC);
  localparam int LED_W  = cnt_w(LED_HALF_CYC);

  state_e                state_q, state_d;
  logic [STAB_W-1:0]     stab_q, stab_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [LED_W-1:0]      div_q, div_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  rdy_q, rdy_d;
  logic                  led_q, led_d;
  logic [LOCK_CNT_W-1:0] loss_q, loss_d;
  logic                  lk_s;

  sync_2ff u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d_i   (bus.pll_locked),
    .q_o   (lk_s)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      gap_q   <= '0;
      div_q   <= '0;
      rst_q   <= '0;
      rdy_q   <= 1'b0;
      led_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      led_q   <= led_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    loss_d  = loss_q;
    div_d   = div_q;
    led_d   = led_q;

    case (state_q)
      WAIT_LOCK: begin
        rst_d  = '0;
        rdy_d  = 1'b0;
        stab_d = '0;
        if (lk_s) begin
          state_d = STABLE;
          stab_d  = STAB_W'(1);
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_W'(LOCK_STABLE_CYC)) begin
          state_d = RELEASE;
          rst_d   = NUM_STAGES'(1);
          gap_d   = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      RELEASE: begin
        if (gap_q == GAP_W'(STAGE_GAP_CYC - 1)) begin
          gap_d = '0;
          // Released stages form a thermometer code growing from bit 0.
          if (&rst_q) begin
            state_d = RUN;
            rdy_d   = 1'b1;
          end else begin
            rst_d = (rst_q << 1) | NUM_STAGES'(1);
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.soft_rst_req) begin
          state_d = HOLD;
          rst_d   = '0;
          rdy_d   = 1'b0;
          gap_d   = '0;
        end
      end
      HOLD: begin
        if (gap_q == GAP_W'(STAGE_GAP_CYC - 1)) begin
          state_d = RELEASE;
          rst_d   = NUM_STAGES'(1);
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '0;
        rdy_d   = 1'b0;
      end
    endcase

    // Lock loss overrides any same-cycle soft reset.
    if (!lk_s && (state_q == RELEASE || state_q == RUN || state_q == HOLD)) begin
      state_d = WAIT_LOCK;
      rst_d   = '0;
      rdy_d   = 1'b0;
      stab_d  = '0;
      gap_d   = '0;
      if (loss_q != '1) loss_d = loss_q + 1'b1;
    end

    if (state_d == RUN) begin
      div_d = '0;
      led_d = 1'b1;
    end else if (div_q == LED_W'(LED_HALF_CYC - 1)) begin
      div_d = '0;
      led_d = ~led_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  assign bus.rst_n_out     = rst_q;
  assign bus.sys_ready     = rdy_q;
  assign bus.lock_loss_cnt = loss_q;
  assign bus.status_led    = led_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with a cycle-indexed expectation queue.
module tb_rst_seq_ctrl;
  import rst_seq_ctrl_pkg::*;

  localparam int NS = 3;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  rst_seq_ctrl_if #(.NUM_STAGES(NS)) bus ();

  rst_seq_ctrl #(
    .LOCK_STABLE_CYC (16),
    .STAGE_GAP_CYC   (4),
    .NUM_STAGES      (NS),
    .LED_HALF_CYC    (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int            at;
    logic [NS-1:0] rst;
    logic          rdy;
    logic [7:0]    cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input logic [NS-1:0] r, input logic rd, input logic [7:0] c);
    exp_t e;
    e.at = at; e.rst = r; e.rdy = rd; e.cnt = c;
    sbq.push_back(e);
  endtask

  // Advance one edge, then compare against the expectation active at cycle c.
  task automatic tick(input string tag, input int c);
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (sbq.size() > 0 && sbq[0].at == c) cur = sbq.pop_front();
    chk($sformatf("%s@%0d rst", tag, c), 32'(bus.rst_n_out), 32'(cur.rst));
    chk($sformatf("%s@%0d rdy", tag, c), 32'(bus.sys_ready), 32'(cur.rdy));
    chk($sformatf("%s@%0d cnt", tag, c), 32'(bus.lock_loss_cnt), 32'(cur.cnt));
  endtask

  task automatic drained(input string tag);
    chk($sformatf("%s sb_left", tag), 32'(sbq.size()), 32'd0);
  endtask

  task automatic power_up(input string tag);
    sys_rst_n = 1'b1;
    bus.pll_locked   = 1'b1;
    bus.soft_rst_req = 1'b0;
    push(0, 3'b000, 1'b0, 8'd0);
    push(18, 3'b001, 1'b0, 8'd0);
    push(22, 3'b011, 1'b0, 8'd0);
    push(26, 3'b111, 1'b0, 8'd0);
    push(30, 3'b111, 1'b1, 8'd0);
    for (int c = 0; c < 34; c++) begin
      tick(tag, c);
      if (c == 6)  chk($sformatf("%s led@6", tag),  32'(bus.status_led), 32'd0);
      if (c == 7)  chk($sformatf("%s led@7", tag),  32'(bus.status_led), 32'd1);
      if (c == 15) chk($sformatf("%s led@15", tag), 32'(bus.status_led), 32'd0);
      if (c == 33) chk($sformatf("%s led_run", tag), 32'(bus.status_led), 32'd1);
    end
    drained(tag);
  endtask

  // Lock drop at c=0 reaches the FSM at c=2; relock sampled at c=1 releases at c=19.
  task automatic lock_drop(input string tag, input logic with_soft, input logic [7:0] cnt_after);
    push(0, 3'b111, 1'b1, cnt_after - 8'd1);
    push(2, 3'b000, 1'b0, cnt_after);
    push(19, 3'b001, 1'b0, cnt_after);
    push(23, 3'b011, 1'b0, cnt_after);
    push(27, 3'b111, 1'b0, cnt_after);
    push(31, 3'b111, 1'b1, cnt_after);
    for (int c = 0; c < 34; c++) begin
      bus.pll_locked   = (c != 0);
      bus.soft_rst_req = with_soft && (c == 2);
      tick(tag, c);
    end
    bus.soft_rst_req = 1'b0;
    drained(tag);
  endtask

  initial begin
    int n_loss;
    bus.pll_locked   = 1'b0;
    bus.soft_rst_req = 1'b0;

    #1;
    chk("reset rst", 32'(bus.rst_n_out), 32'd0);
    chk("reset rdy", 32'(bus.sys_ready), 32'd0);
    chk("reset cnt", 32'(bus.lock_loss_cnt), 32'd0);
    chk("reset led", 32'(bus.status_led), 32'd0);
    repeat (3) @(negedge sys_clk);

    power_up("s1");

    // Glitchy lock after a fresh reset: only the last rise (c=13) qualifies.
    sys_rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push(0, 3'b000, 1'b0, 8'd0);
    push(31, 3'b001, 1'b0, 8'd0);
    push(35, 3'b011, 1'b0, 8'd0);
    push(39, 3'b111, 1'b0, 8'd0);
    push(43, 3'b111, 1'b1, 8'd0);
    for (int c = 0; c < 46; c++) begin
      bus.pll_locked = (c < 10) || (c >= 13);
      tick("s2", c);
    end
    drained("s2");

    lock_drop("s3", 1'b0, 8'd1);

    // Soft reset in RUN: hold for 4, then staged release.
    push(0, 3'b000, 1'b0, 8'd1);
    push(4, 3'b001, 1'b0, 8'd1);
    push(8, 3'b011, 1'b0, 8'd1);
    push(12, 3'b111, 1'b0, 8'd1);
    push(16, 3'b111, 1'b1, 8'd1);
    for (int c = 0; c < 19; c++) begin
      bus.pll_locked   = 1'b1;
      bus.soft_rst_req = (c == 0);
      tick("s4", c);
    end
    bus.soft_rst_req = 1'b0;
    drained("s4");

    lock_drop("s5a", 1'b1, 8'd2);

    // Repeated lock losses during RELEASE until the counter saturates.
    for (n_loss = 3; n_loss <= 260; n_loss++) begin
      bus.pll_locked = 1'b1;
      for (int w = 0; w < 40 && bus.rst_n_out[0] !== 1'b1; w++) @(negedge sys_clk);
      chk($sformatf("s5b lock_wait#%0d", n_loss), 32'(bus.rst_n_out[0]), 32'd1);
      bus.pll_locked = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk($sformatf("s5b cnt#%0d", n_loss), 32'(bus.lock_loss_cnt),
          (n_loss > 255) ? 32'd255 : 32'(n_loss));
      chk($sformatf("s5b rst#%0d", n_loss), 32'(bus.rst_n_out), 32'd0);
    end

    // Async reset mid-release, checked before any further clock edge.
    bus.pll_locked = 1'b1;
    for (int w = 0; w < 60 && bus.rst_n_out !== 3'b011; w++) @(negedge sys_clk);
    chk("s6 reach_011", 32'(bus.rst_n_out), 32'h3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("s6 async rst", 32'(bus.rst_n_out), 32'd0);
    chk("s6 async rdy", 32'(bus.sys_ready), 32'd0);
    chk("s6 async cnt", 32'(bus.lock_loss_cnt), 32'd0);
    chk("s6 async led", 32'(bus.status_led), 32'd0);
    repeat (2) @(negedge sys_clk);
    power_up("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer placed directly downstream of the clock-generation block.
- Consumes the PLL `locked` status and the board reset, qualifies lock stability, then releases staged active-low resets to downstream logic in a fixed order.
- Re-asserts all resets on lock loss or a soft-reset request; exposes a ready flag, a lock-loss event counter and a status LED.

Parameters:
- LOCK_STABLE_CYC, 1024: consecutive synchronized `locked`-high cycles required before release.
- STAGE_GAP_CYC, 256: cycles between successive stage releases; also the soft-reset hold time.
- NUM_STAGES, 3: number of staged reset outputs (≥1).
- LED_HALF_CYC, 25_000_000: LED toggle half-period while not running.

Ports:
- sys_clk  in  1  single clock; all logic in this domain.
- sys_rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock status, asynchronous to sys_clk.
- soft_rst_req  in  1  single-cycle soft-reset request pulse, synchronous.
- rst_n_out  out  NUM_STAGES  staged active-low resets; bit 0 releases first.
- sys_ready  out  1  high only when all stages are released.
- lock_loss_cnt  out  8  saturating count of lock-loss events.
- status_led  out  1  blinks while sequencing, steady high when running.

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - rst_n_out=0, sys_ready=0, lock_loss_cnt=0, status_led=0.
  - All counters cleared; FSM=WAIT_LOCK.
- pll_locked passes through a 2-flop synchronizer (lk_s, 2-cycle latency); only lk_s is used.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN, HOLD.
  - WAIT_LOCK: rst_n_out all 0. lk_s=1 → STABLE with stability counter=1.
  - STABLE: counter increments while lk_s=1. lk_s=0 clears the counter → WAIT_LOCK. When counter reaches LOCK_STABLE_CYC → RELEASE; rst_n_out[0] goes 1 on that transition edge.
  - RELEASE: rst_n_out[k] rises exactly k*STAGE_GAP_CYC cycles after rst_n_out[0]. Released bits stay high. STAGE_GAP_CYC cycles after the last stage rises → RUN; sys_ready rises on that edge.
  - RUN: sys_ready=1, all rst_n_out=1.
  - HOLD: all rst_n_out=0; after STAGE_GAP_CYC cycles → RELEASE, with no lock re-qualification.
- Lock loss: lk_s=0 in RELEASE, RUN or HOLD.
  - On the next edge: all rst_n_out=0 and sys_ready=0 simultaneously; lock_loss_cnt += 1, saturating at 255; → WAIT_LOCK.
  - Lock loss in WAIT_LOCK or STABLE does not increment the counter.
- soft_rst_req=1 in RUN: next edge all rst_n_out=0, sys_ready=0 → HOLD. Ignored in every other state.
- Simultaneous lock loss and soft_rst_req in RUN: lock loss wins (counter increments, → WAIT_LOCK).
- End-to-end latency: pll_locked sampled high at edge t → rst_n_out[0] high at t+LOCK_STABLE_CYC+2. Asynchronous sampling adds ±1 cycle uncertainty.
- status_led:
  - RUN: 1.
  - All other states: toggles every LED_HALF_CYC cycles; the divider free-runs and is cleared on RUN entry.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter widths are $clog2 of the maximum count plus 1; no wrap-around is reachable.

Decomposition:
- Shared package holds:
  - state enum (WAIT_LOCK, STABLE, RELEASE, RUN, HOLD);
  - localparam width helpers for the stability, gap and LED counters;
  - LOCK_CNT_W=8.
- One sub-module: sync_2ff (2-flop synchronizer, asynchronous active-low reset to 0), reused elsewhere for CDC of single-bit status.

Test Plan:
All scenarios use LOCK_STABLE_CYC=16, STAGE_GAP_CYC=4, NUM_STAGES=3, LED_HALF_CYC=8.
1. Power-up: release sys_rst_n, pll_locked=1 from cycle 0.
   → rst_n_out 000→001 at +18, 011 at +22, 111 at +26; sys_ready=1 at +30; lock_loss_cnt=0.
2. Glitchy lock: pll_locked high 10 cycles, low 3, then high.
   → no release until 16 consecutive synced-high cycles after the last rise; lock_loss_cnt stays 0.
3. Lock loss in RUN: drop pll_locked for 1 cycle.
   → 2-cycle sync delay, then all rst_n_out=0 and sys_ready=0 next edge; lock_loss_cnt=1; full re-sequence follows.
4. Soft reset in RUN: 1-cycle soft_rst_req.
   → rst_n_out=000 next edge, held 4 cycles, then staged release 001/011/111 at 4-cycle gaps, sys_ready 4 after; lock_loss_cnt unchanged.
5. Conflict and saturation:
   - soft_rst_req with a simultaneous lock drop → WAIT_LOCK path taken, counter increments.
   - 260 forced lock losses → lock_loss_cnt=255.
6. Async reset mid-RELEASE (rst_n_out=011): assert sys_rst_n.
   → all outputs 0 immediately without a clock edge; restart behaves as scenario 1.
